// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM encoding, default frame
// geometry, and the oversampling ratio shared with tx and baud gen.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    localparam int OVERSAMPLE  = 16;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    function automatic int cnt_width(input int n, input int min_w);
        return ($clog2(n) > min_w) ? $clog2(n) : min_w;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones
// so an idle-high serial line does not look like a start bit.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, no parity. Emits a
// one-clk write strobe per good byte and a one-clk framing error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int SW = cnt_width(SB_TICK, 4);
    localparam int NW = cnt_width(DBIT, 1);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_sync;
    logic [1:0]      state_d, state_q;
    logic [SW-1:0]   s_d, s_q;
    logic [NW-1:0]   n_d, n_q;
    logic [DBIT-1:0] b_d, b_q;
    logic [DBIT-1:0] dout_d, dout_q;
    logic            done_d, done_q;
    logic            ferr_d, ferr_q;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // still low at mid start bit: real frame, else glitch
                        if (!rx_sync) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_sync, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        if (rx_sync) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, corner sequences and random
// frames checked against a queue-based frame model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic       done16, ferr16, done32, ferr32;
    logic [7:0] dout16, dout32;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    logic [7:0] rxq[$];
    int         ferr_cnt = 0;
    int         done32_cnt = 0;
    time        t_done16 = 0;
    time        t_done32 = 0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(done16), .dout(dout16), .frame_err(ferr16)
    );

    uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(done32), .dout(dout32), .frame_err(ferr32)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_cnt = (tick_cnt + 1) % 4;
        s_tick = (tick_cnt == 0);
    end

    always @(negedge clk) begin
        if (done16 || ferr16) begin
            checks++;
            if (done16 && ferr16) begin
                errors++;
                $display("FAIL both_pulses: done=%0b ferr=%0b required not both", done16, ferr16);
            end
        end
        if (done16) begin
            rxq.push_back(dout16);
            t_done16 = $time;
        end
        if (ferr16) ferr_cnt++;
        if (done32) begin
            done32_cnt++;
            t_done32 = $time;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int ncyc);
        rx = v;
        repeat (ncyc) @(negedge clk);
    endtask

    // a bad stop is held low only past its midpoint, then idles long enough
    // for the restarted START to see a high line and drop back to IDLE
    task automatic send_frame(input logic [7:0] data, input bit ok, input int gap);
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) hold(data[i], BIT_CLK);
        if (ok) begin
            hold(1'b1, BIT_CLK);
        end else begin
            hold(1'b0, 48);
            hold(1'b1, 16 + 2 * BIT_CLK);
        end
        if (gap > 0) hold(1'b1, gap);
    endtask

    task automatic clear_mon();
        rxq.delete();
        ferr_cnt = 0;
        done32_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ok;
        bit         glitch;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[3];
    logic [7:0] expq[$];
    logic [7:0] last_good;
    int         exp_ferr;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5};
        vecs[1] = '{8'h81, 1'b0, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1, 0, 8'h3C};

        repeat (4) @(negedge clk);
        chk("reset_dout", dout16, 0);
        chk("reset_done", done16, 0);
        chk("reset_ferr", ferr16, 0);
        chk("reset_state", dut.state_q, IDLE);
        reset = 1'b0;
        hold(1'b1, 20);

        for (int i = 0; i < 3; i++) begin
            clear_mon();
            if (vecs[i].glitch) begin
                hold(1'b0, 20);
                hold(1'b1, 3 * BIT_CLK);
                chk("glitch_no_done", rxq.size(), 0);
                chk("glitch_no_ferr", ferr_cnt, 0);
            end
            send_frame(vecs[i].data, vecs[i].ok, 3 * BIT_CLK);
            chk($sformatf("vec%0d_done", i), rxq.size(), vecs[i].exp_done);
            chk($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_dout", i), dout16, vecs[i].exp_dout);
            if (rxq.size() > 0)
                chk($sformatf("vec%0d_byte", i), rxq[0], vecs[i].exp_dout);
            chk($sformatf("vec%0d_idle", i), dut.state_q, IDLE);
        end

        clear_mon();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 2 * BIT_CLK);
        chk("b2b_count", rxq.size(), 3);
        chk("b2b_ferr", ferr_cnt, 0);
        if (rxq.size() == 3) begin
            chk("b2b_0", rxq[0], 8'h00);
            chk("b2b_1", rxq[1], 8'hFF);
            chk("b2b_2", rxq[2], 8'h55);
        end

        clear_mon();
        hold(1'b0, BIT_CLK);
        hold(1'b1, BIT_CLK);
        hold(1'b1, BIT_CLK);
        hold(1'b1, BIT_CLK);
        hold(1'b0, 32);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_dout", dout16, 0);
        chk("rst_done", done16, 0);
        chk("rst_ferr", ferr16, 0);
        chk("rst_state", dut.state_q, IDLE);
        hold(1'b1, 12 * BIT_CLK);
        chk("rst_no_done", rxq.size(), 0);
        chk("rst_no_ferr", ferr_cnt, 0);
        send_frame(8'h5A, 1'b1, 2 * BIT_CLK);
        chk("rst_next_cnt", rxq.size(), 1);
        chk("rst_next_dout", dout16, 8'h5A);

        reset = 1'b1;
        hold(1'b1, 4);
        reset = 1'b0;
        hold(1'b1, 8);
        clear_mon();
        send_frame(8'hC3, 1'b1, 3 * BIT_CLK);
        chk("sb32_count", done32_cnt, 1);
        chk("sb32_dout", dout32, 8'hC3);
        chk("sb16_dout", dout16, 8'hC3);
        chk("sb32_extra_ns", t_done32 - t_done16, 16 * 4 * 10);

        clear_mon();
        expq.delete();
        exp_ferr = 0;
        last_good = 8'hC3;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            bit ok;
            d = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            if (ok) begin
                expq.push_back(d);
                last_good = d;
            end else begin
                exp_ferr++;
            end
            send_frame(d, ok, $urandom_range(0, 63));
        end
        hold(1'b1, 2 * BIT_CLK);
        chk("rand_count", rxq.size(), expq.size());
        chk("rand_ferr", ferr_cnt, exp_ferr);
        chk("rand_last_dout", dout16, last_good);
        for (int k = 0; k < expq.size() && k < rxq.size(); k++)
            chk($sformatf("rand_byte%0d", k), rxq[k], expq[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
